// File: rtl/hilf6_elem_sel.sv
// hilf6_elem_sel - element selector for the 6-element ISI-shaping DEM.
//
// Converts a 0..6 code into a 6-bit unit-element drive vector. Elements that
// are already on are kept first, because they cost no up-transition. The
// remaining elements are taken in order of the filter's captured SFI state,
// lowest state first. Ties are broken by a fixed or rotating element order.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   clk_en        sample strobe; state advances only on clk_en=1 edges
//   code[2:0]     number of elements to turn on (7 saturates to 6)
//   SFI5..SFI0    loop-filter state outputs, captured at clk_en edges
//   D[5:0]        registered element drive vector
//   ST[5:0]       up-transition vector, combinational from code and registers
//   sat_flag      sticky flag: some captured SFI word reached all-ones
//
// Optional feature: define HILF6_SEL_ROTATE_EN to rotate the tie-break order.
// A pointer then advances mod 6 on every sample, and the element it points at
// wins ties.
module hilf6_elem_sel #(
  parameter int NEL = 6,
  parameter int SW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic [2:0]    code,
  input  logic [SW-1:0] SFI5,
  input  logic [SW-1:0] SFI4,
  input  logic [SW-1:0] SFI3,
  input  logic [SW-1:0] SFI2,
  input  logic [SW-1:0] SFI1,
  input  logic [SW-1:0] SFI0,
  output logic [5:0]    D,
  output logic [5:0]    ST,
  output logic          sat_flag
);

  logic [NEL-1:0] d_q, d_d, d_next;
  logic [SW-1:0]  sfi_q [NEL];
  logic [SW-1:0]  sfi_d [NEL];
  logic [SW-1:0]  sfi_in [NEL];
  logic           sat_q, sat_d;
  logic [SW:0]    key  [NEL];
  logic [2:0]     tord [NEL];
  logic [2:0]     rank [NEL];
  logic [2:0]     k;

`ifdef HILF6_SEL_ROTATE_EN
  logic [2:0] rp_q, rp_d;
`endif

  always_comb begin
    sfi_in[0] = SFI0;
    sfi_in[1] = SFI1;
    sfi_in[2] = SFI2;
    sfi_in[3] = SFI3;
    sfi_in[4] = SFI4;
    sfi_in[5] = SFI5;
  end

  assign k = (code == 3'd7) ? 3'd6 : code;

  // Key 0 means the element is already on. Off elements get 1 + state, so
  // they always rank behind elements that are already on.
  always_comb begin
    for (int unsigned i = 0; i < NEL; i++) begin
      key[i] = d_q[i] ? '0 : ({1'b0, sfi_q[i]} + 1'b1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NEL; i++) begin
`ifdef HILF6_SEL_ROTATE_EN
      logic [3:0] t;
      t = 4'(i) + 4'd6 - {1'b0, rp_q};
      if (t >= 4'd6) t = t - 4'd6;
      tord[i] = t[2:0];
`else
      tord[i] = 3'(i);
`endif
    end
  end

  // Rank by pairwise comparison. Tie orders are distinct, so the ranks
  // form a permutation and exactly k elements satisfy rank < k.
  always_comb begin
    for (int unsigned i = 0; i < NEL; i++) begin
      rank[i] = '0;
      for (int unsigned j = 0; j < NEL; j++) begin
        if (j != i) begin
          if ((key[j] < key[i]) || ((key[j] == key[i]) && (tord[j] < tord[i])))
            rank[i] = rank[i] + 3'd1;
        end
      end
      d_next[i] = (rank[i] < k);
    end
  end

  assign ST = d_next & ~d_q;

  always_comb begin
    d_d   = d_q;
    sat_d = sat_q;
    for (int unsigned i = 0; i < NEL; i++) sfi_d[i] = sfi_q[i];
`ifdef HILF6_SEL_ROTATE_EN
    rp_d = rp_q;
`endif
    if (clk_en) begin
      d_d = d_next;
      for (int unsigned i = 0; i < NEL; i++) begin
        sfi_d[i] = sfi_in[i];
        if (sfi_in[i] == '1) sat_d = 1'b1;
      end
`ifdef HILF6_SEL_ROTATE_EN
      rp_d = (rp_q == 3'd5) ? '0 : (rp_q + 3'd1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= '0;
      sat_q <= 1'b0;
      for (int unsigned i = 0; i < NEL; i++) sfi_q[i] <= '0;
`ifdef HILF6_SEL_ROTATE_EN
      rp_q  <= '0;
`endif
    end else begin
      d_q   <= d_d;
      sat_q <= sat_d;
      for (int unsigned i = 0; i < NEL; i++) sfi_q[i] <= sfi_d[i];
`ifdef HILF6_SEL_ROTATE_EN
      rp_q  <= rp_d;
`endif
    end
  end

  assign D        = d_q;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_hilf6_elem_sel.sv
module tb_hilf6_elem_sel;
  logic       clk = 1'b0;
  logic       rst, clk_en;
  logic [2:0] code;
  logic [3:0] SFI5, SFI4, SFI3, SFI2, SFI1, SFI0;
  logic [5:0] D, ST;
  logic       sat_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilf6_elem_sel #(.NEL(6), .SW(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .code(code),
    .SFI5(SFI5), .SFI4(SFI4), .SFI3(SFI3), .SFI2(SFI2), .SFI1(SFI1), .SFI0(SFI0),
    .D(D), .ST(ST), .sat_flag(sat_flag)
  );

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a greedy pick of the k cheapest elements by cost.
  // The cost is 0 for an element that is already on, otherwise 1 + state.
  // Ties go to the element earliest in the tie order.
  logic [5:0] m_d;
  int         m_sfi [6];
  logic       m_sat;
  int         m_rp;
  bit         m_ok = 0;

  function automatic logic [5:0] pick(input logic [5:0] dq, input int sfi [6],
                                      input int rp, input int k);
    logic [5:0] chosen = '0;
    for (int n = 0; n < k; n++) begin
      int best = -1, bkey = 0, bord = 0;
      for (int i = 0; i < 6; i++) begin
        int key, ord;
        if (chosen[i]) continue;
        key = dq[i] ? 0 : 1 + sfi[i];
        ord = (i - rp + 6) % 6;
        if (best < 0 || key < bkey || (key == bkey && ord < bord)) begin
          best = i; bkey = key; bord = ord;
        end
      end
      chosen[best] = 1'b1;
    end
    return chosen;
  endfunction

  function automatic int keff(input logic [2:0] c);
    return (c == 3'd7) ? 6 : int'(c);
  endfunction

  always @(posedge clk) begin
    int s [6];
    s = '{int'(SFI0), int'(SFI1), int'(SFI2), int'(SFI3), int'(SFI4), int'(SFI5)};
    if (rst) begin
      m_ok  <= 1;
      m_d   <= '0;
      m_sat <= 0;
      m_rp  <= 0;
      m_sfi <= '{0, 0, 0, 0, 0, 0};
    end else if (clk_en) begin
      m_d   <= pick(m_d, m_sfi, m_rp, keff(code));
      m_sfi <= s;
      m_sat <= m_sat | (s[0] == 15) | (s[1] == 15) | (s[2] == 15) |
               (s[3] == 15) | (s[4] == 15) | (s[5] == 15);
`ifdef HILF6_SEL_ROTATE_EN
      m_rp  <= (m_rp + 1) % 6;
`endif
    end
  end

  // Every cycle after the first reset, check D, sat_flag and ST against the
  // model. Inputs change 2 time units after negedge, so sampling at negedge
  // is race free.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_D", D, m_d);
      chk("model_sat", {5'b0, sat_flag}, {5'b0, m_sat});
      chk("model_ST", ST, pick(m_d, m_sfi, m_rp, keff(code)) & ~m_d);
    end
  end

  task automatic step(input logic r, input logic en, input logic [2:0] c,
                      input logic [23:0] s);
    @(negedge clk);
    #2;
    rst = r; clk_en = en; code = c;
    {SFI5, SFI4, SFI3, SFI2, SFI1, SFI0} = s;
  endtask

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] rs;
    rst = 1; clk_en = 1; code = 3'd5;
    {SFI5, SFI4, SFI3, SFI2, SFI1, SFI0} = '0;

    // Reset
    step(1, 1, 5, 24'h0);
    after_edge;
    chk("reset_D", D, 6'b000000);
    chk("reset_sat", {5'b0, sat_flag}, 6'b0);
    step(1, 1, 5, 24'h0);
    step(0, 0, 0, 24'h0);
    #1 chk("post_reset_ST_k0", ST, 6'b000000);

    // First sample. SFI2..0 = 1 is captured for the stay-on test that follows.
    step(0, 1, 3, 24'h000111);
    #1 chk("first_ST", ST, 6'b000111);
    after_edge;
    chk("first_D", D, 6'b000111);

    // Stay-on priority
    step(0, 1, 3, 24'h000111);
    #1 chk("stay_k3_ST", ST, 6'b000000);
    after_edge;
    chk("stay_k3_D", D, 6'b000111);
    step(0, 0, 4, 24'h000111);
    #1 chk("stay_k4_ST", ST, 6'b001000);
    step(0, 1, 1, 24'h000111);
    #1 chk("stay_k1_ST", ST, 6'b000000);
    after_edge;
    chk("stay_k1_D", D, 6'b000001);

    // Shaping order: state {5:0,4:3,3:1,2:2,1:0,0:4}
    step(1, 1, 0, 24'h0);
    step(0, 1, 0, 24'h031204);
    step(0, 0, 2, 24'h031204);
    #1 chk("shape_k2_ST", ST, 6'b100010);

    // Hold: code 4 sets D, then clk_en=0 while code sweeps 0..6
    step(0, 1, 4, 24'h0);
    after_edge;
    chk("shape_k4_D", D, 6'b101110);
    for (int c = 0; c <= 6; c++) begin
      step(0, 0, 3'(c), 24'hFFFFFF);
      after_edge;
      chk("hold_D", D, 6'b101110);
    end
    chk("hold_sat", {5'b0, sat_flag}, 6'b0);

    // Saturating code
    step(0, 1, 7, 24'h0);
    #1 chk("k7_ST", ST, 6'b010001);
    after_edge;
    chk("k7_D", D, 6'b111111);

    // Sticky saturation flag
    step(0, 1, 3, 24'h0F0000);
    after_edge;
    chk("sat_set", {5'b0, sat_flag}, 6'b000001);
    step(0, 1, 2, 24'h0);
    after_edge;
    chk("sat_sticky", {5'b0, sat_flag}, 6'b000001);

    // Random traffic; the compare process checks each cycle
    for (int n = 0; n < 400; n++) begin
      rs = 24'h0;
      for (int e = 0; e < 6; e++)
        rs[4*e +: 4] = ($urandom_range(0, 31) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), rs);
    end

    // Mid-stream reset clears everything
    step(1, 0, 6, 24'h0);
    after_edge;
    chk("midreset_D", D, 6'b000000);
    chk("midreset_sat", {5'b0, sat_flag}, 6'b0);
    step(0, 1, 2, 24'h0);
    #1 chk("midreset_ST", ST, 6'b000011);
    after_edge;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
